// File: rtl/wb_vga_fetch.sv
// Wishbone burst-read master feeding the pixel pipeline: fetches one framebuffer per
// start_i pulse as 16-beat incrementing bursts and buffers the words in a FWFT FIFO.
module wb_vga_fetch #(
  parameter int ADDRESS    = 23,
  parameter int BURST_LOG2 = 4,
  parameter int FIFO_LOG2  = 6,
  parameter int COUNT_W    = 20,
  parameter int RETRY_WAIT = 4
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic [ADDRESS-1:0] frame_base_i,
  input  logic [COUNT_W-1:0] frame_words_i,
  input  logic               start_i,
  output logic               wb_cyc_o,
  output logic               wb_stb_o,
  output logic               wb_we_o,
  output logic [2:0]         wb_cti_o,
  output logic [1:0]         wb_bte_o,
  output logic [ADDRESS-1:0] wb_adr_o,
  output logic [3:0]         wb_sel_o,
  input  logic               wb_ack_i,
  input  logic               wb_rty_i,
  input  logic               wb_err_i,
  input  logic [31:0]        wb_dat_i,
  output logic [31:0]        px_dat_o,
  output logic               px_valid_o,
  input  logic               px_ready_i,
  output logic               busy_o,
  output logic               err_o,
  output logic               underflow_o
);
  localparam int BURST_LEN  = 1 << BURST_LOG2;
  localparam int FIFO_DEPTH = 1 << FIFO_LOG2;
  localparam int BO_W       = (RETRY_WAIT > 1) ? $clog2(RETRY_WAIT) : 1;

  typedef enum logic [1:0] {IDLE, WAIT_SPACE, BURST, BACKOFF} state_t;

  state_t                state;
  logic [ADDRESS-1:0]    burst_base;
  logic [BURST_LOG2-1:0] beat;
  logic [COUNT_W-1:0]    words_left;
  logic [BO_W-1:0]       bo_cnt;
  logic                  cyc_r;

  logic [31:0]           mem [FIFO_DEPTH];
  logic [FIFO_LOG2-1:0]  wr_ptr;
  logic [FIFO_LOG2-1:0]  rd_ptr;
  logic [FIFO_LOG2:0]    fill;

  logic last_beat;
  logic space_ok;
  logic push;
  logic pop;
  logic flush;

  assign last_beat = &beat;
  assign space_ok  = fill <= (FIFO_LOG2+1)'(FIFO_DEPTH - BURST_LEN);
  // A restart or an error discards whatever the slave returns in that same cycle.
  assign push  = (state == BURST) && wb_ack_i && !wb_err_i && !start_i;
  assign pop   = px_valid_o && px_ready_i;
  assign flush = start_i || ((state == BURST) && wb_err_i);

  assign wb_cyc_o = cyc_r;
  assign wb_stb_o = cyc_r;
  assign wb_we_o  = 1'b0;
  assign wb_bte_o = 2'b00;
  assign wb_sel_o = 4'hF;
  assign wb_adr_o = burst_base + ADDRESS'(beat);
  assign wb_cti_o = cyc_r ? (last_beat ? 3'b111 : 3'b010) : 3'b000;

  assign px_valid_o  = (fill != '0);
  assign px_dat_o    = px_valid_o ? mem[rd_ptr] : 32'h0;
  assign underflow_o = px_ready_i && busy_o && !px_valid_o;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      burst_base <= '0;
      beat       <= '0;
      words_left <= '0;
      bo_cnt     <= '0;
      cyc_r      <= 1'b0;
      busy_o     <= 1'b0;
      err_o      <= 1'b0;
    end else if (start_i) begin
      state      <= WAIT_SPACE;
      burst_base <= frame_base_i;
      beat       <= '0;
      words_left <= frame_words_i;
      cyc_r      <= 1'b0;
      busy_o     <= 1'b1;
      err_o      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
        end
        WAIT_SPACE: begin
          if (space_ok) begin
            cyc_r <= 1'b1;
            state <= BURST;
          end
        end
        BURST: begin
          if (wb_err_i) begin
            cyc_r  <= 1'b0;
            err_o  <= 1'b1;
            busy_o <= 1'b0;
            state  <= IDLE;
          end else if (wb_ack_i) begin
            beat       <= beat + 1'b1;
            words_left <= words_left - 1'b1;
            if (last_beat) begin
              cyc_r      <= 1'b0;
              burst_base <= burst_base + ADDRESS'(BURST_LEN);
              if (words_left == COUNT_W'(1)) begin
                busy_o <= 1'b0;
                state  <= IDLE;
              end else begin
                state <= WAIT_SPACE;
              end
            end
          end else if (wb_rty_i) begin
            // beat is left untouched so the burst resumes at the first unacked word
            cyc_r  <= 1'b0;
            bo_cnt <= BO_W'(RETRY_WAIT - 1);
            state  <= BACKOFF;
          end
        end
        BACKOFF: begin
          if (bo_cnt == '0) begin
            cyc_r <= 1'b1;
            state <= BURST;
          end else begin
            bo_cnt <= bo_cnt - 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (push) mem[wr_ptr] <= wb_dat_i;
  end

endmodule

// File: doc/wb_vga_fetch.md
Name: wb_vga_fetch

Overview:
- Wishbone burst-read master that sits directly upstream of wb_sdram_ctrl on the video path.
- Each frame, it fetches the framebuffer from SDRAM as 16-beat incrementing bursts (CTI 010, closed by CTI 111).
- Fetched 32-bit words are buffered in an internal FIFO and presented to the pixel pipeline as a valid/ready stream.
- It honours the controller's retry (wb_rty_i, e.g. during SDRAM init) and error responses.

Parameters:
- ADDRESS, 23, Wishbone word-address width; matches wb_sdram_ctrl ADDRESS.
- BURST_LOG2, 4, log2 of beats per burst (16).
- FIFO_LOG2, 6, log2 of FIFO depth in 32-bit words (64).
- COUNT_W, 20, width of the frame word count.
- RETRY_WAIT, 4, idle cycles after a retry before re-asserting cyc/stb.

Ports:
- wb_clk_i, in, 1, system clock; all logic on the rising edge.
- wb_rst_i, in, 1, asynchronous active-high reset.
- frame_base_i, in, ADDRESS, frame start word address; low BURST_LOG2 bits must be 0.
- frame_words_i, in, COUNT_W, words per frame; must be a nonzero multiple of 16.
- start_i, in, 1, single-cycle pulse (vsync) that starts or restarts a frame.
- wb_cyc_o, out, 1, Wishbone cycle.
- wb_stb_o, out, 1, Wishbone strobe.
- wb_we_o, out, 1, tied 0.
- wb_cti_o, out, 3, cycle type identifier.
- wb_bte_o, out, 2, tied 00 (linear).
- wb_adr_o, out, ADDRESS, word address.
- wb_sel_o, out, 4, tied 1111.
- wb_ack_i, in, 1, Wishbone acknowledge.
- wb_rty_i, in, 1, Wishbone retry.
- wb_err_i, in, 1, Wishbone error.
- wb_dat_i, in, 32, read data.
- px_dat_o, out, 32, FIFO head word (first-word fall-through).
- px_valid_o, out, 1, FIFO not empty.
- px_ready_i, in, 1, consumer pops when valid && ready.
- busy_o, out, 1, frame fetch in progress.
- err_o, out, 1, sticky; set by wb_err_i, cleared by start_i.
- underflow_o, out, 1, one-cycle pulse on px_ready_i while busy_o=1 and FIFO empty.

Behaviour:
- Reset values: all outputs 0; FSM=IDLE; FIFO empty; address and word counters 0.
- FSM states: IDLE, WAIT_SPACE, BURST, BACKOFF.
- IDLE -> WAIT_SPACE on start_i:
  - latch frame_base_i and frame_words_i;
  - flush the FIFO;
  - clear err_o;
  - set busy_o.
- WAIT_SPACE -> BURST when FIFO free space >= 16. The cyc/stb assertion is registered and appears on the next cycle.
- BURST:
  - cyc_o=stb_o=1.
  - adr_o = burst base + beat index.
  - cti_o=010 for beats 0..14; cti_o=111 on beat 15.
  - Each ack pushes wb_dat_i and advances beat index and word counter.
  - Ack on beat 15: deassert cyc/stb on the next cycle. Go to WAIT_SPACE if words remain; otherwise go to IDLE and clear busy_o.
- Retry: wb_rty_i in BURST (with no ack that cycle) -> drop cyc/stb next cycle, go to BACKOFF for RETRY_WAIT cycles, then re-enter BURST.
  - The burst resumes at the first unacked beat.
  - cti rules are unchanged; a resume at beat 15 uses cti 111.
  - No data is pushed on a retry.
- Error: wb_err_i in BURST -> drop cyc/stb, set err_o, flush FIFO, go to IDLE, clear busy_o.
- start_i while busy:
  - terminate any cycle (cyc/stb low next cycle);
  - a same-cycle ack is discarded;
  - flush the FIFO, relatch inputs, restart from WAIT_SPACE.
  - start_i has priority over ack, rty and err.
- FIFO:
  - simultaneous push and pop are allowed at any fill level, including full and empty;
  - free-space check uses the registered count, so no push ever occurs at full;
  - pointers wrap modulo 2^FIFO_LOG2.
- Addressing: the word address wraps modulo 2^ADDRESS with no flag.
- Wishbone rules: adr/cti stay stable while stb=1 until ack/rty/err.
- Reset asserted mid-burst: cyc/stb go to 0 immediately (asynchronous).

Test Plan:
- Retry during init: BFM returns rty for the first 50 stb cycles, then acks; frame_base=0, frame_words=32 -> no FIFO push during retries, each retry followed by 4 idle cycles, then 32 words 0..31 delivered in order.
- Burst sequencing: frame_words=16, base=0x000100, slave acks every cycle -> adr 0x100..0x10F, cti 010 x15 then 111, cyc low the cycle after the 16th ack, busy_o low.
- Backpressure: frame_words=128, px_ready_i=0 -> fetch stops with FIFO at exactly 64 (4 bursts). Raising ready resumes bursts; the 128 words arrive with data = address pattern.
- Mid-burst retry: rty at beat 7 -> resume at base+7 with cti 010, no duplicate or lost words.
- Error and restart: err at beat 3 -> err_o=1, FIFO empty, busy_o=0. A following start_i clears err_o and fetches cleanly.
- Underflow and vsync abort: ready held high with slave wait states -> underflow_o pulses. start_i mid-burst -> cyc drops next cycle, FIFO flushed, new frame begins at the new base.
